// File: rtl/chacha_keystream_ctrl.sv
// ChaCha20 keystream sequencer: runs the round core once per block, launches the serializer,
// buffers bytes in a show-ahead FIFO and truncates to the message length. Option: CHACHA_CTRL_OVF_GUARD_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start_i
// ST_CORE    | round core running the current block, waiting core_done_i
// ST_WAIT    | waiting until the FIFO can absorb one whole block
// ST_SER     | collecting 64 serializer beats, pushing the in-length bytes
// ST_DRAIN   | all bytes queued; done_o once the consumer empties the FIFO
module chacha_keystream_ctrl #(
    parameter int CNT_BITS   = 32,
    parameter int LEN_BITS   = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [CNT_BITS-1:0] init_counter_i,
    input  logic [LEN_BITS-1:0] msg_len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                core_start_o,
    output logic [CNT_BITS-1:0] core_counter_o,
    input  logic                core_done_i,
    output logic                ser_valid_o,
    input  logic [7:0]          ser_byte_i,
    input  logic                ser_byte_valid_i,
    output logic [7:0]          ks_byte_o,
    output logic                ks_valid_o,
    input  logic                ks_ready_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CORE  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SER   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CNT_BITS-1:0] counter_q, counter_d;
    logic [LEN_BITS-1:0] bytes_left_q, bytes_left_d;
    logic [5:0]          beat_q, beat_d;
    logic                core_start_q, core_start_d;
    logic                ser_valid_q, ser_valid_d;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       free_cnt;

    logic                accept, push, pop, fifo_empty, space_ok, last_beat, ctr_stop;
    logic [LEN_BITS-1:0] bl_after;

    assign accept     = (state_q == ST_IDLE) && start_i;
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && ks_ready_i;
    assign push       = (state_q == ST_SER) && ser_byte_valid_i && (bytes_left_q != '0);
    assign last_beat  = (state_q == ST_SER) && ser_byte_valid_i && (beat_q == 6'd63);
    assign bl_after   = push ? (bytes_left_q - LEN_BITS'(1)) : bytes_left_q;
    // A pop in the same cycle frees a slot before the next block's first push can land.
    assign free_cnt   = CW'(FIFO_DEPTH) - count_q + CW'(pop);
    assign space_ok   = (free_cnt >= CW'(64));

`ifdef CHACHA_CTRL_OVF_GUARD_EN
    assign ctr_stop = (counter_q == '1);
`else
    assign ctr_stop = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        bytes_left_d = bytes_left_q;
        beat_d       = beat_q;
        core_start_d = 1'b0;
        ser_valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    counter_d    = init_counter_i;
                    bytes_left_d = msg_len_i;
                    beat_d       = '0;
                    if (msg_len_i == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d      = ST_CORE;
                        core_start_d = 1'b1;
                    end
                end
            end
            ST_CORE: begin
                if (core_done_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (space_ok) begin
                    state_d     = ST_SER;
                    ser_valid_d = 1'b1;
                    beat_d      = '0;
                end
            end
            ST_SER: begin
                if (ser_byte_valid_i) begin
                    beat_d       = beat_q + 6'd1;
                    bytes_left_d = bl_after;
                end
                if (last_beat) begin
                    if (bl_after == '0) begin
                        state_d = ST_DRAIN;
                    end else if (ctr_stop) begin
                        state_d      = ST_DRAIN;
                        bytes_left_d = '0;
                    end else begin
                        state_d      = ST_CORE;
                        counter_d    = counter_q + CNT_BITS'(1);
                        core_start_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            bytes_left_q <= '0;
            beat_q       <= '0;
            core_start_q <= 1'b0;
            ser_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            bytes_left_q <= bytes_left_d;
            beat_q       <= beat_d;
            core_start_q <= core_start_d;
            ser_valid_q  <= ser_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ser_byte_i;
        end
    end

`ifdef CHACHA_CTRL_OVF_GUARD_EN
    logic ovf_q, err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (last_beat && (bl_after != '0) && ctr_stop) begin
                ovf_q <= 1'b1;
            end
            if (done_o && ovf_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q | (done_o & ovf_q);
`else
    assign err_o = 1'b0;
`endif

    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DRAIN) && fifo_empty;
    assign core_start_o   = core_start_q;
    assign core_counter_o = counter_q;
    assign ser_valid_o    = ser_valid_q;
    assign ks_valid_o     = !fifo_empty;
    assign ks_byte_o      = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// Bench for chacha_keystream_ctrl: round-core and serializer stubs, random consumer,
// and a message-level reference model of the expected byte stream and block counters.
module tb_chacha_keystream_ctrl;

`ifdef CHACHA_CTRL_OVF_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] init_counter_i;
    logic [15:0] msg_len_i;
    logic        busy_o, done_o, err_o, core_start_o, ser_valid_o, ks_valid_o;
    logic [31:0] core_counter_o;
    logic        core_done_i;
    logic [7:0]  ser_byte_i;
    logic        ser_byte_valid_i;
    logic [7:0]  ks_byte_o;
    logic        ks_ready_i;

    chacha_keystream_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .init_counter_i(init_counter_i), .msg_len_i(msg_len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .core_start_o(core_start_o), .core_counter_o(core_counter_o),
        .core_done_i(core_done_i), .ser_valid_o(ser_valid_o),
        .ser_byte_i(ser_byte_i), .ser_byte_valid_i(ser_byte_valid_i),
        .ks_byte_o(ks_byte_o), .ks_valid_o(ks_valid_o), .ks_ready_i(ks_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    int ready_mode = 0;
    bit junk_en    = 1'b1;

    int          cs_cnt = 0, sv_cnt = 0, done_cnt = 0;
    logic [7:0]  rx_q[$];
    logic [31:0] ctr_log[$];

    logic [7:0]  exp_q[$];
    logic [31:0] exp_ctr_q[$];
    logic        exp_err;
    int          sb, cs0, sv0, d0, cl0;

    // Keystream byte the serializer stub emits for byte i of block ctr.
    function automatic logic [7:0] ks_f(input logic [31:0] c, input int i);
        logic [7:0] a;
        a = c[7:0] * 8'd37;
        return a ^ c[15:8] ^ (c[23:16] + c[31:24]) ^ 8'(i * 11 + 3);
    endfunction

    initial begin : core_stub
        bit cbusy = 0;
        int cdly  = 0;
        core_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            core_done_i = 1'b0;
            if (!rst_ni) begin
                cbusy = 0;
            end else if (cbusy) begin
                if (cdly == 0) begin
                    core_done_i = 1'b1;
                    cbusy = 0;
                end else begin
                    cdly--;
                end
            end else if (core_start_o) begin
                cbusy = 1;
                cdly  = int'($urandom_range(0, 4));
            end else if (junk_en && ($urandom % 5 == 0)) begin
                core_done_i = 1'b1;
            end
        end
    end

    initial begin : ser_stub
        bit          sact = 0;
        int          sidx = 0;
        logic [31:0] sctr = '0;
        ser_byte_valid_i = 1'b0;
        ser_byte_i       = 8'h00;
        forever begin
            @(negedge clk_i);
            ser_byte_valid_i = 1'b0;
            if (!rst_ni) begin
                sact = 0;
            end else begin
                if (!sact && ser_valid_o) begin
                    sact = 1;
                    sidx = 0;
                    sctr = core_counter_o;
                end else if (!sact && junk_en && ($urandom % 4 == 0)) begin
                    ser_byte_valid_i = 1'b1;
                    ser_byte_i       = 8'hEE;
                end
                if (sact && ($urandom % 3 != 0)) begin
                    ser_byte_valid_i = 1'b1;
                    ser_byte_i       = ks_f(sctr, sidx);
                    sidx++;
                    if (sidx == 64) sact = 0;
                end
            end
        end
    end

    initial begin : consumer
        ks_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0:       ks_ready_i = 1'b1;
                1:       ks_ready_i = ($urandom % 4 != 0);
                default: ks_ready_i = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (core_start_o) begin
                    cs_cnt++;
                    ctr_log.push_back(core_counter_o);
                end
                if (ser_valid_o) sv_cnt++;
                if (done_o) done_cnt++;
                if (ks_valid_o && ks_ready_i) rx_q.push_back(ks_byte_o);
            end
        end
    end

    task automatic build_exp(input logic [31:0] c, input int len);
        int          rem;
        int          n;
        logic [31:0] ctr;
        exp_q.delete();
        exp_ctr_q.delete();
        exp_err = 1'b0;
        rem = len;
        ctr = c;
        while (rem > 0) begin
            exp_ctr_q.push_back(ctr);
            n = (rem > 64) ? 64 : rem;
            for (int i = 0; i < n; i++) exp_q.push_back(ks_f(ctr, i));
            rem -= n;
            if (rem > 0) begin
                if (GUARD && ctr == 32'hFFFF_FFFF) begin
                    exp_err = 1'b1;
                    rem = 0;
                end else begin
                    ctr = ctr + 32'd1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic start_msg(input logic [31:0] c, input int len);
        build_exp(c, len);
        sb  = rx_q.size();
        cs0 = cs_cnt;
        sv0 = sv_cnt;
        d0  = done_cnt;
        cl0 = ctr_log.size();
        start_i        = 1'b1;
        init_counter_i = c;
        msg_len_i      = 16'(len);
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b expected 1", busy_o);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_accept: got %b expected 0", err_o);
        end
    endtask

    task automatic finish_msg(input string tag);
        int n = 0;
        while (!done_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: got done=%b expected 1 within 5000 cycles", tag, done_o);
            do_reset();
            return;
        end
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL %s err_at_done: got %b expected %b", tag, err_o, exp_err);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got busy=%b done=%b expected 0 0", tag, busy_o, done_o);
        end
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL %s err_hold: got %b expected %b", tag, err_o, exp_err);
        end
        checks++;
        if (rx_q.size() - sb !== exp_q.size()) begin
            errors++;
            $display("FAIL %s byte_count: got %0d expected %0d", tag, rx_q.size() - sb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[sb + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %h expected %h", tag, i, rx_q[sb + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (cs_cnt - cs0 !== exp_ctr_q.size() || sv_cnt - sv0 !== exp_ctr_q.size()) begin
            errors++;
            $display("FAIL %s block_count: got core_start=%0d ser_valid=%0d expected %0d", tag,
                     cs_cnt - cs0, sv_cnt - sv0, exp_ctr_q.size());
        end else begin
            for (int i = 0; i < exp_ctr_q.size(); i++) begin
                checks++;
                if (ctr_log[cl0 + i] !== exp_ctr_q[i]) begin
                    errors++;
                    $display("FAIL %s block_ctr[%0d]: got %h expected %h", tag, i, ctr_log[cl0 + i], exp_ctr_q[i]);
                end
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - d0);
        end
    endtask

    task automatic run_msg(input logic [31:0] c, input int len, input string tag);
        start_msg(c, len);
        finish_msg(tag);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy_o, done_o, err_o, core_start_o, ser_valid_o, ks_valid_o} !== 6'b0 ||
            core_counter_o !== 32'h0 || ks_byte_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b cs=%b sv=%b kv=%b ctr=%h byte=%h expected all 0",
                     busy_o, done_o, err_o, core_start_o, ser_valid_o, ks_valid_o, core_counter_o, ks_byte_o);
        end
    endtask

    task automatic test_single_block();
        ready_mode = 0;
        run_msg(32'd1, 64, "single");
    endtask

    task automatic test_two_block();
        ready_mode = 1;
        run_msg(32'd5, 100, "two_block");
    endtask

    task automatic test_zero_len();
        ready_mode = 0;
        start_msg(32'h1234, 0);
        checks++;
        if (done_o !== 1'b1 || core_start_o !== 1'b0 || ks_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b cs=%b kv=%b expected 1 0 0", done_o, core_start_o, ks_valid_o);
        end
        finish_msg("zero_len");
    endtask

    task automatic test_backpressure();
        logic [7:0] held = 8'h00;
        bit         have = 0;
        ready_mode = 2;
        repeat (2) @(negedge clk_i);
        start_msg($urandom, 192);
        repeat (300) begin
            @(negedge clk_i);
            if (ks_valid_o) begin
                if (!have) begin
                    held = ks_byte_o;
                    have = 1;
                end else begin
                    checks++;
                    if (ks_byte_o !== held) begin
                        errors++;
                        $display("FAIL bp_hold: got %h expected %h", ks_byte_o, held);
                    end
                end
            end
        end
        checks++;
        if (sv_cnt - sv0 !== 1 || cs_cnt - cs0 !== 2 || ks_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got ser_valid=%0d core_start=%0d kv=%b expected 1 2 1",
                     sv_cnt - sv0, cs_cnt - cs0, ks_valid_o);
        end
        ready_mode = 0;
        finish_msg("backpressure");
    endtask

    task automatic test_start_during_busy();
        ready_mode = 1;
        start_msg($urandom, 150);
        for (int k = 0; k < 3; k++) begin
            repeat (int'($urandom_range(2, 8))) @(negedge clk_i);
            start_i        = 1'b1;
            init_counter_i = $urandom;
            msg_len_i      = 16'($urandom_range(1, 500));
            @(negedge clk_i);
            start_i = 1'b0;
        end
        finish_msg("start_busy");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ready_mode = 1;
        start_msg($urandom, 192);
        while (sv_cnt == sv0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, err_o, core_start_o, ser_valid_o, ks_valid_o} !== 6'b0 || core_counter_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b err=%b cs=%b sv=%b kv=%b ctr=%h expected all 0",
                     busy_o, done_o, err_o, core_start_o, ser_valid_o, ks_valid_o, core_counter_o);
        end
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (ks_valid_o !== 1'b0 || busy_o !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL mid_reset_abort: got kv=%b busy=%b done_pulses=%0d expected 0 0 0",
                     ks_valid_o, busy_o, done_cnt - d0);
        end
        run_msg(32'd9, 70, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            ready_mode = 1;
            run_msg($urandom, int'($urandom_range(1, 300)), "random");
        end
    endtask

    task automatic test_overflow();
        ready_mode = 1;
        run_msg(32'hFFFF_FFFF, 128, "overflow");
        repeat (4) @(negedge clk_i);
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL ovf_err_sticky: got %b expected %b", err_o, exp_err);
        end
        run_msg(32'd2, 10, "post_overflow");
    endtask

    initial begin
        rst_ni         = 1'b0;
        start_i        = 1'b0;
        init_counter_i = '0;
        msg_len_i      = '0;
        test_reset();
        test_single_block();
        test_two_block();
        test_zero_len();
        test_backpressure();
        test_start_during_busy();
        test_reset_mid();
        test_random();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
